// File: rtl/score_segment_display.sv
// Four-digit seven-segment score display: sequential double-dabble BCD conversion
// of a saturated binary score, plus strobe-driven anode multiplexing.
module score_segment_display #(
  parameter int SCORE_WIDTH   = 14,
  parameter int BLANK_LEADING = 1
) (
  input  logic                   MasterClock,
  input  logic                   Reset,
  input  logic                   fastClock,
  input  logic [SCORE_WIDTH-1:0] Score,
  input  logic                   Load,
  output logic                   Busy,
  output logic [6:0]             seg,
  output logic [3:0]             an,
  output logic                   dp
);

  localparam int STEP_W = $clog2(SCORE_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } stateT;

  stateT                  state, nextState;
  logic [STEP_W-1:0]      stepCount, nextStepCount;
  logic [SCORE_WIDTH-1:0] binReg, nextBinReg;
  logic [15:0]            bcdReg, nextBcdReg;
  logic [15:0]            displayReg, nextDisplayReg;
  logic                   nextBusy;
  logic [SCORE_WIDTH-1:0] clampedScore;
  logic [15:0]            adjustedBcd;

  logic [1:0]             digitIndex;
  logic [3:0]             digitValue;
  logic [3:0]             blankMask;

  function automatic logic [15:0] addThree(input logic [15:0] bcd);
    logic [15:0] result;
    for (int i = 0; i < 4; i++) begin
      result[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    return result;
  endfunction

  function automatic logic [6:0] encodeDigit(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = 7'b1111111;
    endcase
    return pattern;
  endfunction

  // Narrow scores can never exceed 9999, so the compare simply never fires there.
  always_comb begin
    if (32'(Score) > 32'd9999) clampedScore = SCORE_WIDTH'(14'd9999);
    else                       clampedScore = Score;
  end

  assign adjustedBcd = addThree(bcdReg);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    nextState      = state;
    nextStepCount  = stepCount;
    nextBinReg     = binReg;
    nextBcdReg     = bcdReg;
    nextDisplayReg = displayReg;
    nextBusy       = Busy;
    case (state)
      IDLE: begin
        if (Load) begin
          nextBinReg    = clampedScore;
          nextBcdReg    = '0;
          nextStepCount = '0;
          nextBusy      = 1'b1;
          nextState     = CONVERT;
        end
      end
      CONVERT: begin
        nextBcdReg    = {adjustedBcd[14:0], binReg[SCORE_WIDTH-1]};
        nextBinReg    = {binReg[SCORE_WIDTH-2:0], 1'b0};
        nextStepCount = stepCount + 1'b1;
        if (stepCount == STEP_W'(SCORE_WIDTH - 1)) nextState = COMMIT;
      end
      COMMIT: begin
        nextDisplayReg = bcdReg;
        nextBusy       = 1'b0;
        nextState      = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      state      <= IDLE;
      stepCount  <= '0;
      binReg     <= '0;
      bcdReg     <= '0;
      displayReg <= '0;
      Busy       <= 1'b0;
    end else begin
      state      <= nextState;
      stepCount  <= nextStepCount;
      binReg     <= nextBinReg;
      bcdReg     <= nextBcdReg;
      displayReg <= nextDisplayReg;
      Busy       <= nextBusy;
    end
  end

  // A digit is blank when it and every more significant digit are zero; digit 0 always shows.
  always_comb begin
    blankMask    = 4'b0000;
    blankMask[3] = (displayReg[15:12] == 4'd0);
    blankMask[2] = blankMask[3] && (displayReg[11:8] == 4'd0);
    blankMask[1] = blankMask[2] && (displayReg[7:4] == 4'd0);
    if (BLANK_LEADING == 0) blankMask = 4'b0000;
  end

  assign digitValue = displayReg[{digitIndex, 2'b00} +: 4];

  // digitIndex names the digit lit by the next strobe, so the first strobe after reset lights digit 0.
  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      digitIndex <= 2'd0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
    end else if (fastClock) begin
      digitIndex <= digitIndex + 2'd1;
      an         <= ~(4'b0001 << digitIndex);
      seg        <= blankMask[digitIndex] ? 7'b1111111 : encodeDigit(digitValue);
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_score_segment_display.sv
// Scoreboard bench for score_segment_display: stimulus queues expected scan outputs,
// a monitor compares them after every strobe edge.
module tb_score_segment_display;

  logic        MasterClock = 1'b0;
  logic        Reset       = 1'b0;
  logic        fastClock   = 1'b0;
  logic        Load        = 1'b0;
  logic [13:0] Score       = '0;
  logic        Busy;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  score_segment_display #(.SCORE_WIDTH(14), .BLANK_LEADING(1)) dut (
    .MasterClock(MasterClock),
    .Reset      (Reset),
    .fastClock  (fastClock),
    .Score      (Score),
    .Load       (Load),
    .Busy       (Busy),
    .seg        (seg),
    .an         (an),
    .dp         (dp)
  );

  always #5 MasterClock = ~MasterClock;

  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } scanT;

  scanT expQ[$];
  int   checks = 0;
  int   errors = 0;
  logic strobeSeen = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, actual, expected);
    end
  endtask

  // Monitor: a strobe sampled at a posedge is checked at the following negedge.
  always @(posedge MasterClock) strobeSeen <= fastClock && !Reset;

  always @(negedge MasterClock) begin
    if (strobeSeen) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected scan: an=%b seg=%b with nothing expected", an, seg);
      end else begin
        scanT e;
        e = expQ.pop_front();
        check("scan an", 32'(an), 32'(e.an));
        check("scan seg", 32'(seg), 32'(e.seg));
      end
    end
  end

  // Pushes one full round (digit 0..3) and strobes it, spaced or held continuously high.
  task automatic scanRound(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input bit continuous);
    expQ.push_back('{an: 4'b1110, seg: s0});
    expQ.push_back('{an: 4'b1101, seg: s1});
    expQ.push_back('{an: 4'b1011, seg: s2});
    expQ.push_back('{an: 4'b0111, seg: s3});
    if (continuous) begin
      fastClock = 1'b1;
      repeat (4) @(negedge MasterClock);
      fastClock = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        fastClock = 1'b1;
        @(negedge MasterClock);
        fastClock = 1'b0;
        @(negedge MasterClock);
      end
    end
    repeat (2) @(negedge MasterClock);
  endtask

  // Caller is at a negedge; returns at the negedge right after the sampling edge.
  task automatic loadScore(input logic [13:0] value);
    Score = value;
    Load  = 1'b1;
    @(negedge MasterClock);
    Load  = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (Busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge MasterClock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cycles;

    // Reset state
    @(negedge MasterClock);
    Reset = 1'b1;
    repeat (2) @(negedge MasterClock);
    check("reset Busy", 32'(Busy), 32'd0);
    check("reset an", 32'(an), 32'b1111);
    check("reset seg", 32'(seg), 32'(SB));
    check("reset dp", 32'(dp), 32'd1);
    Reset = 1'b0;
    @(negedge MasterClock);
    scanRound(S0, SB, SB, SB, 1'b0);

    // 1234: latency, digit order, wrap with continuous strobe
    loadScore(14'd1234);
    check("Busy after load", 32'(Busy), 32'd1);
    waitIdle(cycles);
    check("Busy cycles 1234", 32'(cycles), 32'd15);
    scanRound(S4, S3, S2, S1, 1'b0);
    scanRound(S4, S3, S2, S1, 1'b1);

    // Leading-zero blanking, with loads accepted in the first Busy-low cycle
    loadScore(14'd7);
    waitIdle(cycles);
    check("Busy cycles 7", 32'(cycles), 32'd15);
    loadScore(14'd0);
    waitIdle(cycles);
    check("Busy cycles back-to-back 0", 32'(cycles), 32'd15);
    scanRound(S0, SB, SB, SB, 1'b1);
    loadScore(14'd7);
    waitIdle(cycles);
    scanRound(S7, SB, SB, SB, 1'b1);

    // Saturation
    loadScore(14'd12000);
    waitIdle(cycles);
    check("Busy cycles 12000", 32'(cycles), 32'd15);
    scanRound(S9, S9, S9, S9, 1'b0);

    // Load during conversion is ignored; Busy still falls at edge k+15
    loadScore(14'd55);
    repeat (2) @(negedge MasterClock);
    loadScore(14'd99);
    waitIdle(cycles);
    check("Busy cycles with ignored load", 32'(cycles + 3), 32'd15);
    scanRound(S5, S5, SB, SB, 1'b1);

    // Reset in cycle 5 of a conversion discards the result
    loadScore(14'd8888);
    repeat (4) @(negedge MasterClock);
    check("Busy before mid reset", 32'(Busy), 32'd1);
    Reset = 1'b1;
    @(negedge MasterClock);
    check("Busy after mid reset", 32'(Busy), 32'd0);
    check("an after mid reset", 32'(an), 32'b1111);
    Reset = 1'b0;
    repeat (20) @(negedge MasterClock);
    check("Busy stays low after mid reset", 32'(Busy), 32'd0);
    scanRound(S0, SB, SB, SB, 1'b1);

    repeat (3) @(negedge MasterClock);
    check("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
